fetch_sequencer: RTL and testbench

//  Sequences the instruction-fetch datapath: owns the fetch PC and issues one request at a time on the

---
 rtl/fetch_sequencer.sv | 105 ++++++++++
 tb/tb_fetch_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC, issues one imem request at a time, presents {pc, insn} to decode.
module fetch_sequencer #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  input  logic              stall_i,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DWIDTH-1:0] imem_rdata_i,
  output logic              f_valid_o,
  output logic [AWIDTH-1:0] f_pc_o,
  output logic [DWIDTH-1:0] f_insn_o,
  output logic              misalign_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  state_t state, state_n;
  logic [AWIDTH-1:0] pc, pc_n, f_pc_n, skid_pc, skid_pc_n;
  logic [DWIDTH-1:0] f_insn_n, skid_insn, skid_insn_n;
  logic kill, kill_n, f_valid_n, skid_valid, skid_valid_n, misalign_n, free;
  assign free = !f_valid_o || !stall_i;
  assign imem_req_o = (state == REQ) && free;
  assign imem_addr_o = pc;
  always_comb begin
    state_n = state;
    pc_n = pc;
    kill_n = kill;
    f_valid_n = f_valid_o && stall_i;
    f_pc_n = f_pc_o;
    f_insn_n = f_insn_o;
    skid_valid_n = skid_valid;
    skid_pc_n = skid_pc;
    skid_insn_n = skid_insn;
    misalign_n = misalign_o;
    case (state)
      IDLE: state_n = REQ;
      REQ: state_n = (imem_req_o && imem_gnt_i) ? WAIT : REQ;
      WAIT: if (imem_rvalid_i) begin
        if (kill) begin
          kill_n = 1'b0;
          state_n = REQ;
        end else if (free) begin
          f_valid_n = 1'b1;
          f_pc_n = pc;
          f_insn_n = imem_rdata_i;
          pc_n = pc + AWIDTH'(4);
          state_n = REQ;
        end else begin
          skid_valid_n = 1'b1;
          skid_pc_n = pc;
          skid_insn_n = imem_rdata_i;
          pc_n = pc + AWIDTH'(4);
          state_n = HOLD;
        end
      end
      HOLD: if (!stall_i) begin
        f_valid_n = 1'b1;
        f_pc_n = skid_pc;
        f_insn_n = skid_insn;
        skid_valid_n = 1'b0;
        state_n = REQ;
      end
    endcase
    // A redirect overrides everything above; a granted-but-unanswered fetch must be killed.
    if (redirect_i && state != IDLE) begin
      pc_n = {redirect_pc_i[AWIDTH-1:2], 2'b00};
      f_valid_n = 1'b0;
      skid_valid_n = 1'b0;
      misalign_n = misalign_o || (redirect_pc_i[1:0] != 2'b00);
      kill_n = (state == REQ && imem_req_o && imem_gnt_i) || (state == WAIT && !imem_rvalid_i);
      state_n = kill_n ? WAIT : REQ;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= BASEADDR;
      kill <= 1'b0;
      f_valid_o <= 1'b0;
      f_pc_o <= '0;
      f_insn_o <= '0;
      skid_valid <= 1'b0;
      skid_pc <= '0;
      skid_insn <= '0;
      misalign_o <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      kill <= kill_n;
      f_valid_o <= f_valid_n;
      f_pc_o <= f_pc_n;
      f_insn_o <= f_insn_n;
      skid_valid <= skid_valid_n;
      skid_pc <= skid_pc_n;
      skid_insn <= skid_insn_n;
      misalign_o <= misalign_n;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: random imem/decode/execute traffic checked against an in-order fetch stream model.
module tb_fetch_sequencer;
  localparam logic [31:0] BASE = 32'h0100_0000;
  logic clk = 1'b0, reset = 1'b1, redirect_i = 1'b0, stall_i = 1'b0;
  logic imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0, imem_rdata_i = '0;
  logic imem_req_o, f_valid_o, misalign_o;
  logic [31:0] imem_addr_o, f_pc_o, f_insn_o;
  int tests = 0, fails = 0;
  logic [31:0] exp_pc, next_fetch, resp_addr, prev_pc, prev_insn, redir_tgt;
  bit exp_mis, outstanding, hold_pend, redir_rand, redir_at_rv, pend_spur;
  int resp_cnt, since_rst, consumed;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .stall_i(stall_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .f_valid_o(f_valid_o), .f_pc_o(f_pc_o), .f_insn_o(f_insn_o), .misalign_o(misalign_o)
  );

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_9617;
  endfunction

  function automatic logic [31:0] pick_tgt();
    int sel;
    sel = int'($urandom_range(2));
    if (sel == 0) return BASE + 32'($urandom_range(63)) * 32'd4;
    if (sel == 1) return 32'hFFFF_FFF0 + 32'($urandom_range(15));
    return $urandom();
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic reset_dut(input bit spur);
    @(negedge clk);
    reset = 1'b1;
    redirect_i = 1'b0;
    stall_i = 1'b0;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    imem_rvalid_i = spur;
    imem_rdata_i = 32'hDEAD_BEEF;
    pend_spur = spur;
    exp_pc = BASE;
    next_fetch = BASE;
    exp_mis = 1'b0;
    outstanding = 1'b0;
    hold_pend = 1'b0;
    since_rst = 0;
    #1;
    chk("rst_req", imem_req_o, 0);
    chk("rst_addr", imem_addr_o, BASE);
    chk("rst_fvalid", f_valid_o, 0);
    chk("rst_fpc", f_pc_o, 0);
    chk("rst_finsn", f_insn_o, 0);
    chk("rst_misalign", misalign_o, 0);
  endtask

  task automatic cycle(input int p_stall, input int p_redir, input int p_gnt, input int max_lat, input int p_spur);
    bit busy, rv_ok, fire;
    @(negedge clk);
    since_rst++;
    if (hold_pend) begin
      chk("hold_valid", f_valid_o, 1);
      chk("hold_pc", f_pc_o, prev_pc);
      chk("hold_insn", f_insn_o, prev_insn);
    end
    chk("misalign", misalign_o, exp_mis);
    busy = outstanding;
    stall_i = $urandom_range(99) < p_stall;
    rv_ok = outstanding && resp_cnt == 0;
    if (rv_ok) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i = insn_of(resp_addr);
      outstanding = 1'b0;
    end else begin
      if (outstanding) resp_cnt--;
      imem_rvalid_i = pend_spur || (!outstanding && $urandom_range(99) < p_spur);
      imem_rdata_i = 32'hDEAD_BEEF;
    end
    pend_spur = 1'b0;
    fire = redir_at_rv ? rv_ok : ($urandom_range(99) < p_redir);
    redirect_i = fire;
    redirect_pc_i = redir_rand ? pick_tgt() : redir_tgt;
    imem_gnt_i = $urandom_range(99) < p_gnt;
    #1;
    if (since_rst == 1) begin
      chk("first_req", imem_req_o, 1);
      chk("first_addr", imem_addr_o, BASE);
      chk("first_fvalid", f_valid_o, 0);
    end
    if (busy) chk("req_in_wait", imem_req_o, 0);
    if (f_valid_o && stall_i) chk("req_stalled", imem_req_o, 0);
    if (imem_req_o && imem_gnt_i) begin
      chk("fetch_addr", imem_addr_o, next_fetch);
      next_fetch += 32'd4;
      outstanding = 1'b1;
      resp_addr = imem_addr_o;
      resp_cnt = int'($urandom_range(max_lat));
    end
    hold_pend = 1'b0;
    if (!fire && f_valid_o) begin
      if (stall_i) begin
        hold_pend = 1'b1;
        prev_pc = f_pc_o;
        prev_insn = f_insn_o;
      end else begin
        chk("f_pc", f_pc_o, exp_pc);
        chk("f_insn", f_insn_o, insn_of(exp_pc));
        exp_pc += 32'd4;
        consumed++;
      end
    end
    if (fire) begin
      exp_pc = {redirect_pc_i[31:2], 2'b00};
      next_fetch = exp_pc;
      if (redirect_pc_i[1:0] != 2'b00) exp_mis = 1'b1;
    end
  endtask

  initial begin
    int c0, held;
    redir_rand = 1'b0;
    redir_at_rv = 1'b0;
    redir_tgt = BASE;
    consumed = 0;
    // 1: streaming, 1-cycle imem, no stall
    reset_dut(1'b0);
    repeat (22) cycle(0, 0, 100, 0, 0);
    chk("t1_throughput", consumed, 10);
    // 2: long stall while an instruction is presented
    held = 0;
    for (int i = 0; i < 40 && held < 6; i++) begin
      cycle(100, 0, 100, 0, 0);
      if (f_valid_o) held++;
    end
    chk("t2_held", held, 6);
    c0 = consumed;
    repeat (8) cycle(0, 0, 100, 0, 0);
    chk("t2_resume", 32'(consumed - c0 >= 2), 1);
    // 3: redirect coinciding with a response
    redir_tgt = 32'h0100_0200;
    redir_at_rv = 1'b1;
    for (int i = 0; i < 20 && !redirect_i; i++) cycle(0, 0, 100, 1, 0);
    redir_at_rv = 1'b0;
    chk("t3_fired", redirect_i, 1);
    c0 = consumed;
    repeat (10) cycle(0, 0, 100, 1, 0);
    chk("t3_progress", 32'(consumed > c0), 1);
    // 4: PC wraps past the top of the address space
    redir_tgt = 32'hFFFF_FFFC;
    cycle(0, 100, 100, 0, 0);
    c0 = consumed;
    repeat (12) cycle(0, 0, 100, 0, 0);
    chk("t4_wrap", 32'(consumed - c0 >= 3), 1);
    // 5: misaligned redirect is aligned and remembered
    redir_tgt = 32'h0100_0102;
    cycle(0, 100, 100, 0, 0);
    c0 = consumed;
    for (int i = 0; i < 300 && consumed < c0 + 21; i++) cycle(20, 0, 70, 2, 5);
    chk("t5_fetches", 32'(consumed >= c0 + 21), 1);
    chk("t5_misalign", misalign_o, 1);
    // 6: reset while a fetch is outstanding, stale response afterwards
    for (int i = 0; i < 20 && !outstanding; i++) cycle(0, 0, 100, 3, 0);
    chk("t6_outstanding", 32'(outstanding), 1);
    reset_dut(1'b1);
    c0 = consumed;
    repeat (20) cycle(0, 0, 100, 1, 0);
    chk("t6_progress", 32'(consumed > c0), 1);
    // random traffic
    redir_rand = 1'b1;
    for (int s = 0; s < 5; s++) begin
      int ps, pg;
      reset_dut(s[0]);
      c0 = consumed;
      ps = int'($urandom_range(50));
      pg = int'($urandom_range(100, 30));
      repeat (500) cycle(ps, 4, pg, 4, 5);
      chk("live", 32'(consumed > c0), 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
